// File: rtl/encrypt_ctrl_if.sv
// encrypt_ctrl_if: bus bundle between the encryption sequencer, the dual-port
// public-key SRAM and the encrypt accumulator datapath.
//   mem_req            read strobe shared by both key ports
//   mem_addr1/2        port-1 (even column) / port-2 (odd column) addresses
//   mem_rdata1/2       key data, valid one cycle after mem_req
//   dp_en              datapath operands valid this cycle
//   dp_row             datapath row index
//   dp_op1/2           masked lane operands
//   dp_done            datapath clear/finish strobe
// master = sequencer side, slave = memory/datapath side.
interface encrypt_ctrl_if #(
  parameter int CIPHERTEXT_WIDTH = 10,
  parameter int DIM_WIDTH        = 4,
  parameter int ADDR_WIDTH       = 9
);
  logic                        mem_req;
  logic [ADDR_WIDTH-1:0]       mem_addr1;
  logic [ADDR_WIDTH-1:0]       mem_addr2;
  logic [CIPHERTEXT_WIDTH-1:0] mem_rdata1;
  logic [CIPHERTEXT_WIDTH-1:0] mem_rdata2;
  logic                        dp_en;
  logic [DIM_WIDTH-1:0]        dp_row;
  logic [CIPHERTEXT_WIDTH-1:0] dp_op1;
  logic [CIPHERTEXT_WIDTH-1:0] dp_op2;
  logic                        dp_done;

  modport master (
    output mem_req, mem_addr1, mem_addr2,
    input  mem_rdata1, mem_rdata2,
    output dp_en, dp_row, dp_op1, dp_op2, dp_done
  );

  modport slave (
    input  mem_req, mem_addr1, mem_addr2,
    output mem_rdata1, mem_rdata2,
    input  dp_en, dp_row, dp_op1, dp_op2, dp_done
  );
endinterface

// File: rtl/encrypt_ctrl.sv
// encrypt_ctrl: sequencer for the LWE encryption accumulator datapath.
// Walks the public key (A rows then the b row) two columns per cycle, masks
// each lane with the latched selection vector r, injects the scaled plaintext
// into the b row, flushes the last row and signals completion.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start         begin encryption (only honoured in IDLE)
//   plaintext     message, latched on accepted start
//   rand_bits     selection vector r, latched on accepted start
//   busy          high in every non-IDLE state
//   finished      one-cycle pulse in DONE
//   bus           key-memory read ports and datapath lanes (master side)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// ISSUE | one column-pair read per cycle; previous pair presented to dp
// DRAIN | no read; last issued pair presented to dp
// MSG   | scaled plaintext added into the b row
// FLUSH | row index steps past b so the datapath emits the b-row sum
// DONE  | dp_done / finished pulse
module encrypt_ctrl #(
  parameter int PLAINTEXT_WIDTH  = 6,
  parameter int CIPHERTEXT_WIDTH = 10,
  parameter int DIMENSION        = 10,
  parameter int DIM_WIDTH        = 4,
  parameter int BIG_N            = 30,
  parameter int N_WIDTH          = 5,
  parameter int ADDR_WIDTH       = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [PLAINTEXT_WIDTH-1:0] plaintext,
  input  logic [BIG_N-1:0]           rand_bits,
  output logic                       busy,
  output logic                       finished,
  encrypt_ctrl_if.master             bus
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_MSG, S_FLUSH, S_DONE} state_t;

  localparam logic [DIM_WIDTH-1:0] LAST_ROW  = DIM_WIDTH'(DIMENSION);
  localparam logic [DIM_WIDTH-1:0] FLUSH_ROW = DIM_WIDTH'(DIMENSION + 1);
  localparam logic [N_WIDTH:0]     N_EXT     = (N_WIDTH + 1)'(BIG_N);
  localparam int                   MSG_SHIFT = CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH;

  state_t                     state, state_nxt;
  logic [PLAINTEXT_WIDTH-1:0] pt_q;
  logic [BIG_N-1:0]           r_q;
  logic [DIM_WIDTH-1:0]       row;
  logic [N_WIDTH-1:0]         col;

  // operand stage: metadata of the pair issued last cycle
  logic                       pv;
  logic [DIM_WIDTH-1:0]       prow;
  logic                       pm1, pm2;

  logic [N_WIDTH:0]            col_p1, col_p2;
  logic                        row_wrap, has_lane2;
  logic                        mask1, mask2;
  logic [ADDR_WIDTH-1:0]       base_addr;
  logic [CIPHERTEXT_WIDTH-1:0] msg_term;

  assign col_p1    = {1'b0, col} + (N_WIDTH + 1)'(1);
  assign col_p2    = {1'b0, col} + (N_WIDTH + 1)'(2);
  assign row_wrap  = (col_p2 >= N_EXT);
  // with odd BIG_N the final pair of a row has no second column
  assign has_lane2 = (col_p1 < N_EXT);
  assign mask1     = |(r_q & (BIG_N'(1) << col));
  assign mask2     = has_lane2 && (|(r_q & (BIG_N'(1) << col_p1)));
  assign base_addr = ADDR_WIDTH'(row) * ADDR_WIDTH'(BIG_N) + ADDR_WIDTH'(col);
  assign msg_term  = CIPHERTEXT_WIDTH'(CIPHERTEXT_WIDTH'(pt_q) << MSG_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pt_q  <= '0;
      r_q   <= '0;
      row   <= '0;
      col   <= '0;
      pv    <= 1'b0;
      prow  <= '0;
      pm1   <= 1'b0;
      pm2   <= 1'b0;
    end else begin
      state <= state_nxt;
      pv    <= (state == S_ISSUE);
      case (state)
        S_IDLE: begin
          if (start) begin
            pt_q <= plaintext;
            r_q  <= rand_bits;
            row  <= '0;
            col  <= '0;
          end
        end
        S_ISSUE: begin
          prow <= row;
          pm1  <= mask1;
          pm2  <= mask2;
          if (row_wrap) begin
            col <= '0;
            row <= row + DIM_WIDTH'(1);
          end else begin
            col <= col + N_WIDTH'(2);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = (state != S_IDLE);
    finished      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_addr1 = '0;
    bus.mem_addr2 = '0;
    bus.dp_en     = 1'b0;
    bus.dp_row    = '0;
    bus.dp_op1    = '0;
    bus.dp_op2    = '0;
    bus.dp_done   = 1'b0;

    // operand stage output, live while reads are in flight
    if ((state == S_ISSUE || state == S_DRAIN) && pv) begin
      bus.dp_en  = 1'b1;
      bus.dp_row = prow;
      bus.dp_op1 = pm1 ? bus.mem_rdata1 : '0;
      bus.dp_op2 = pm2 ? bus.mem_rdata2 : '0;
    end

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        bus.mem_req   = 1'b1;
        bus.mem_addr1 = base_addr;
        bus.mem_addr2 = has_lane2 ? base_addr + ADDR_WIDTH'(1) : base_addr;
        if (row_wrap && row == LAST_ROW) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_MSG;
      S_MSG: begin
        bus.dp_en  = 1'b1;
        bus.dp_row = LAST_ROW;
        bus.dp_op1 = msg_term;
        state_nxt  = S_FLUSH;
      end
      S_FLUSH: begin
        bus.dp_row = FLUSH_ROW;
        state_nxt  = S_DONE;
      end
      S_DONE: begin
        bus.dp_row  = FLUSH_ROW;
        bus.dp_done = 1'b1;
        finished    = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_encrypt_ctrl.sv
// Bench for encrypt_ctrl: two small instances (DIMENSION=2 with BIG_N=4 and
// BIG_N=3). Each run is compared cycle by cycle against an expected trace
// built from the key walk described in plain loops.
module tb_encrypt_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_drv = 1'b0;
  logic [5:0] pt_drv = '0;
  logic [3:0] r_drv = '0;
  int         sel = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  logic start_a, start_b;
  assign start_a = start_drv && (sel == 0);
  assign start_b = start_drv && (sel == 1);

  encrypt_ctrl_if #(.CIPHERTEXT_WIDTH(10), .DIM_WIDTH(4), .ADDR_WIDTH(9)) bus_a ();
  encrypt_ctrl_if #(.CIPHERTEXT_WIDTH(10), .DIM_WIDTH(4), .ADDR_WIDTH(9)) bus_b ();
  logic busy_a, fin_a, busy_b, fin_b;

  encrypt_ctrl #(.DIMENSION(2), .DIM_WIDTH(4), .BIG_N(4), .N_WIDTH(3), .ADDR_WIDTH(9)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .plaintext(pt_drv), .rand_bits(r_drv),
    .busy(busy_a), .finished(fin_a), .bus(bus_a.master));

  encrypt_ctrl #(.DIMENSION(2), .DIM_WIDTH(4), .BIG_N(3), .N_WIDTH(2), .ADDR_WIDTH(9)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .plaintext(pt_drv), .rand_bits(r_drv[2:0]),
    .busy(busy_b), .finished(fin_b), .bus(bus_b.master));

  // key memories; unrequested cycles return garbage
  logic [9:0] mem_a [16];
  logic [9:0] mem_b [16];
  always @(posedge clk) begin
    bus_a.mem_rdata1 <= bus_a.mem_req ? mem_a[bus_a.mem_addr1[3:0]] : 10'($urandom);
    bus_a.mem_rdata2 <= bus_a.mem_req ? mem_a[bus_a.mem_addr2[3:0]] : 10'($urandom);
    bus_b.mem_rdata1 <= bus_b.mem_req ? mem_b[bus_b.mem_addr1[3:0]] : 10'($urandom);
    bus_b.mem_rdata2 <= bus_b.mem_req ? mem_b[bus_b.mem_addr2[3:0]] : 10'($urandom);
  end

  // observed vector: busy fin req a1 a2 en row op1 op2 done
  logic [46:0] got_a, got_b, got;
  assign got_a = {busy_a, fin_a, bus_a.mem_req, bus_a.mem_addr1, bus_a.mem_addr2,
                  bus_a.dp_en, bus_a.dp_row, bus_a.dp_op1, bus_a.dp_op2, bus_a.dp_done};
  assign got_b = {busy_b, fin_b, bus_b.mem_req, bus_b.mem_addr1, bus_b.mem_addr2,
                  bus_b.dp_en, bus_b.dp_row, bus_b.dp_op1, bus_b.dp_op2, bus_b.dp_done};
  assign got = (sel == 0) ? got_a : got_b;

  // expected trace, indexed by cycle after accepted start
  logic       e_busy [64];
  logic       e_fin  [64];
  logic       e_req  [64];
  logic [8:0] e_a1   [64];
  logic [8:0] e_a2   [64];
  logic       e_en   [64];
  logic [3:0] e_row  [64];
  logic [9:0] e_op1  [64];
  logic [9:0] e_op2  [64];
  logic       e_done [64];

  function automatic logic [9:0] memv(input int a);
    return (sel == 0) ? mem_a[a] : mem_b[a];
  endfunction

  task automatic fill_mem(input bit seq);
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = seq ? 10'(i + 1) : 10'($urandom);
      mem_b[i] = seq ? 10'(i + 1) : 10'($urandom);
    end
  endtask

  task automatic build_model(input int ncol, input logic [3:0] r, input logic [5:0] pt,
                             output int lat);
    int k;
    k = 0;
    for (int i = 0; i < 64; i++) begin
      e_busy[i] = 0; e_fin[i] = 0; e_req[i] = 0; e_a1[i] = 0; e_a2[i] = 0;
      e_en[i] = 0; e_row[i] = 0; e_op1[i] = 0; e_op2[i] = 0; e_done[i] = 0;
    end
    for (int row = 0; row <= 2; row++) begin
      for (int c = 0; c < ncol; c += 2) begin
        int a1, a2;
        bit lane2;
        a1 = row * ncol + c;
        lane2 = (c + 1 < ncol);
        a2 = lane2 ? a1 + 1 : a1;
        e_req[1+k] = 1; e_a1[1+k] = 9'(a1); e_a2[1+k] = 9'(a2);
        e_en[2+k]  = 1; e_row[2+k] = 4'(row);
        e_op1[2+k] = r[c] ? memv(a1) : 10'd0;
        e_op2[2+k] = (lane2 && r[c+1]) ? memv(a2) : 10'd0;
        k++;
      end
    end
    lat = k + 4;
    for (int i = 1; i <= lat; i++) e_busy[i] = 1;
    e_en[k+2]  = 1; e_row[k+2] = 4'd2; e_op1[k+2] = 10'((int'(pt) * 16) % 1024);
    e_row[k+3] = 4'd3;
    e_row[k+4] = 4'd3; e_fin[k+4] = 1; e_done[k+4] = 1;
  endtask

  // mode 0: plain run, 1: start held + inputs changed mid-run, 2: reset at cycle 4
  task automatic run_scenario(input int s, input logic [3:0] r, input logic [5:0] pt,
                              input int mode);
    int lat;
    logic [46:0] exp_v;
    sel = s;
    rst_n = 1'b1;
    build_model((s == 0) ? 4 : 3, r, pt, lat);
    @(negedge clk);
    pt_drv = pt; r_drv = r; start_drv = 1'b1;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (mode != 1) start_drv = 1'b0;
      if (mode == 1 && c == 3) begin pt_drv = 6'($urandom); r_drv = 4'($urandom); end
      if (mode == 2 && c >= 5) exp_v = '0;
      else exp_v = {e_busy[c], e_fin[c], e_req[c], e_a1[c], e_a2[c], e_en[c], e_row[c],
                    e_op1[c], e_op2[c], e_done[c]};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL trace cfg=%0d mode=%0d cyc=%0d got=%h exp=%h", s, mode, c, got, exp_v);
      end
      if (mode == 2 && c == 4) rst_n = 1'b0;
      if (mode == 2 && c == 5) rst_n = 1'b1;
    end
    if (mode == 1) begin
      int fins;
      fins = 0;
      @(negedge clk);
      start_drv = 1'b0;
      checks++;
      if (got[46] !== 1'b1 || got[44] !== 1'b1 || got[43:35] !== 9'd0) begin
        errors++;
        $display("FAIL restart busy/req/a1 got=%b/%b/%0d exp=1/1/0", got[46], got[44], got[43:35]);
      end
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (got[45] === 1'b1) fins++;
        if (got[46] === 1'b0) break;
      end
      checks++;
      if (got[46] !== 1'b0 || fins != 1) begin
        errors++;
        $display("FAIL restart_end busy=%b fins=%0d exp busy=0 fins=1", got[46], fins);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      checks++;
      if (got !== 47'd0) begin
        errors++;
        $display("FAIL reset cfg=%0d got=%h exp=0", s, got);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full_mask();
    fill_mem(1'b1);
    run_scenario(0, 4'b1111, 6'd5, 0);
  endtask

  task automatic test_half_mask();
    fill_mem(1'b1);
    run_scenario(0, 4'b0101, 6'd5, 0);
  endtask

  task automatic test_odd_columns();
    fill_mem(1'b1);
    run_scenario(1, 4'b0111, 6'd5, 0);
    fill_mem(1'b0);
    run_scenario(1, 4'b0111, 6'($urandom), 0);
  endtask

  task automatic test_start_hold();
    fill_mem(1'b0);
    run_scenario(0, 4'($urandom), 6'($urandom), 1);
    run_scenario(1, 4'($urandom), 6'($urandom), 1);
  endtask

  task automatic test_mid_reset();
    fill_mem(1'b1);
    run_scenario(0, 4'b1111, 6'd5, 2);
    run_scenario(0, 4'b1111, 6'd5, 0);
  endtask

  task automatic test_max_plaintext();
    fill_mem(1'b0);
    run_scenario(0, 4'($urandom), 6'd63, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      fill_mem(1'b0);
      run_scenario($urandom_range(0, 1), 4'($urandom), 6'($urandom), 0);
    end
  endtask

  initial begin
    fill_mem(1'b1);
    test_reset();
    test_full_mask();
    test_half_mask();
    test_odd_columns();
    test_start_hold();
    test_mid_reset();
    test_max_plaintext();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
